// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed nibbles/masks, per-digit slots with
// a dark gap at the start of each slot, active-low digit enables and segments.
`timescale 1ns/1ps
module seg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYC    = 1000,
  parameter int HEX_EN     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic [NUM_DIGITS-1:0]   blank_mask_i,
  input  logic                    lz_en_i,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic [7:0]              seg_o,
  output logic                    frame_tick_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]              seg_q, seg_d;

  logic                    cnt_wrap;
  logic                    in_gap_d;
  logic [3:0]              nib;
  logic                    dp_sel, blank_sel, lz_upper, suppress;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [7:0]              pat;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    if (HEX_EN == 0 && n > 4'h9) p = 8'hFF;
    return p[6:0];
  endfunction

  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    tick_d   = cnt_wrap && (idx_q == IDX_LAST);
  end

  generate
    if (GAP_CYC == 0) begin : g_no_gap
      assign in_gap_d = 1'b0;
    end else begin : g_gap
      assign in_gap_d = (cnt_d < CW'(GAP_CYC));
    end
  endgenerate

  // Pattern is evaluated for the digit about to be lit, i.e. the next-cycle index.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    lz_upper  = 1'b1;
    dig_sel   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib       = value_q[4*i +: 4];
        dp_sel    = dp_q[i];
        blank_sel = blank_q[i];
        dig_sel[i] = 1'b0;
      end
      if (IW'(i) >= idx_d && value_q[4*i +: 4] != 4'h0) lz_upper = 1'b0;
    end
    suppress = lz_en_i && (idx_d != '0) && lz_upper;
    if (blank_sel)     pat = 8'hFF;
    else if (suppress) pat = {~dp_sel, 7'h7F};
    else               pat = {~dp_sel, decode(nib)};
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    seg_d   = seg_q;
    case (state_q)
      ST_GAP: begin
        if (!in_gap_d) begin
          state_d = ST_ON;
          dig_d   = dig_sel;
          seg_d   = pat;
        end
      end
      ST_ON: begin
        if (in_gap_d) begin
          state_d = ST_GAP;
          dig_d   = '1;
          seg_d   = 8'hFF;
        end else if (cnt_d == '0) begin
          // gapless scan: switch straight to the next digit at the slot boundary
          dig_d = dig_sel;
          seg_d = pat;
        end
      end
      default: begin
        state_d = ST_GAP;
        dig_d   = '1;
        seg_d   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_GAP;
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      dig_q   <= '1;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (load_i) begin
      value_q <= value_i;
      dp_q    <= dp_mask_i;
      blank_q <= blank_mask_i;
    end
  end

  assign dig_o        = dig_q;
  assign seg_o        = seg_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus queues expected per-slot {dig,seg}; monitors pop and check.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_mask, blank_mask;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame_tick;

  logic        rst2, load2;
  logic [15:0] value2;
  logic [3:0]  zero4 = 4'h0;
  logic        zero1 = 1'b0;
  logic [3:0]  dig2;
  logic [7:0]  seg2;
  logic        tick2;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GAP_CYC(2), .HEX_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .dp_mask_i(dp_mask),
    .blank_mask_i(blank_mask), .lz_en_i(lz_en), .dig_o(dig), .seg_o(seg),
    .frame_tick_o(frame_tick));

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GAP_CYC(0), .HEX_EN(0)) dut2 (
    .clk_i(clk), .rst_i(rst2), .load_i(load2), .value_i(value2), .dp_mask_i(zero4),
    .blank_mask_i(zero4), .lz_en_i(zero1), .dig_o(dig2), .seg_o(seg2),
    .frame_tick_o(tick2));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;
  exp_t q[$];
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    q.push_back('{4'hE, s0});
    q.push_back('{4'hD, s1});
    q.push_back('{4'hB, s2});
    q.push_back('{4'h7, s3});
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_tick && n < 40);
    chk("tick_seen", frame_tick, 1);
  endtask

  task automatic load_frame(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
    @(negedge clk);
    value = v; dp_mask = dp; blank_mask = bl; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // main DUT monitor
  logic [3:0] prev_dig = 4'hF;
  int   run_len = 0, gap_len = 0, tick_gap = 0;
  bit   gap_valid = 1'b0, tick_seen = 1'b0;
  exp_t cur = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_dig  = 4'hF;
      run_len   = 0;
      gap_len   = 0;
      gap_valid = 1'b0;
      tick_seen = 1'b0;
      tick_gap  = 0;
    end else if (mon_en) begin
      tick_gap++;
      if (frame_tick) begin
        chk("tick_in_gap", dig, 4'hF);
        if (tick_seen) chk("tick_period", tick_gap, 32);
        tick_seen = 1'b1;
        tick_gap  = 0;
      end
      if (dig != prev_dig) begin
        if (prev_dig != 4'hF) begin
          chk("on_len", run_len, 6);
          gap_valid = 1'b1;
          gap_len   = 0;
        end
        if (dig != 4'hF) begin
          if (prev_dig == 4'hF && gap_valid) chk("gap_len", gap_len, 2);
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL queue_empty: got dig %0h seg %0h expected no ON phase", dig, seg);
          end else begin
            cur = q.pop_front();
            chk("dig", dig, cur.dig);
            chk("seg_start", seg, cur.seg);
          end
          run_len = 1;
        end
      end else if (dig != 4'hF) begin
        run_len++;
        chk("seg_hold", seg, cur.seg);
      end
      if (dig == 4'hF) begin
        chk("gap_seg", seg, 8'hFF);
        gap_len++;
      end
      prev_dig = dig;
    end
  end

  // gapless, HEX_EN=0 DUT monitor (value2 = 321F)
  bit         mon2 = 1'b0;
  logic [3:0] prev2 = 4'hF;
  int         run2 = 0, phases2 = 0;
  logic [7:0] e2;

  always @(posedge clk) begin
    #1;
    if (!rst2) begin
      if (tick2 && !mon2) begin
        mon2  = 1'b1;
        prev2 = dig2;
        run2  = 0;
      end
      if (mon2) begin
        case (dig2)
          4'hE:    e2 = 8'hFF;
          4'hD:    e2 = 8'hF9;
          4'hB:    e2 = 8'hA4;
          4'h7:    e2 = 8'hB0;
          default: e2 = 8'h00;
        endcase
        chk("dig2_onehot", $countones(~dig2), 1);
        chk("seg2", seg2, e2);
        if (dig2 != prev2) begin
          chk("slot2_len", run2, 8);
          phases2++;
          run2 = 1;
        end else begin
          run2++;
        end
        prev2 = dig2;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nt;
    rst = 1'b1; rst2 = 1'b1; load = 1'b0; load2 = 1'b0; lz_en = 1'b0;
    value = 16'h0; dp_mask = 4'h0; blank_mask = 4'h0; value2 = 16'h321F;
    repeat (3) @(negedge clk);
    chk("reset_dig", dig, 4'hF);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_tick", frame_tick, 0);

    // release with 1234 loaded on the first edge
    value = 16'h1234; load = 1'b1; load2 = 1'b1; mon_en = 1'b1;
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    load = 1'b0; load2 = 1'b0;

    wait_tick(); load_frame(16'h1234, 4'b0000, 4'b0000, 1'b0);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);

    wait_tick(); load_frame(16'h00A0, 4'b0100, 4'b0000, 1'b1);
    push4(8'hC0, 8'h88, 8'h7F, 8'hFF);

    wait_tick(); load_frame(16'h00A0, 4'b0100, 4'b0000, 1'b0);
    push4(8'hC0, 8'h88, 8'h40, 8'hC0);

    wait_tick(); load_frame(16'h8888, 4'b0010, 4'b0010, 1'b0);
    push4(8'h80, 8'hFF, 8'h80, 8'h80);

    // new value loaded mid-ON of digit 1 shows from digit 2 onward
    wait_tick(); load_frame(16'h1111, 4'b0000, 4'b0000, 1'b0);
    push4(8'hF9, 8'hF9, 8'h92, 8'h92);
    repeat (11) @(negedge clk);
    value = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;

    // async reset mid-ON of digit 0
    wait_tick(); load_frame(16'h7777, 4'b0000, 4'b0000, 1'b0);
    q.push_back('{4'hE, 8'hF8});
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_dig", dig, 4'hF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_tick", frame_tick, 0);
    push4(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (frame_tick) nt++;
    end
    chk("tick_at_release", nt, 0);
    wait_tick();
    @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained", q.size(), 0);
    chk("dut2_phases", (phases2 >= 16) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver.
- Latches a packed nibble vector plus per-digit decimal-point and blank masks into shadow registers.
- Scans the digits one at a time with a dead-time gap between digits to stop ghosting, and decodes each nibble to an active-low 8-bit segment pattern.
- Sits between game/counter logic and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (legal range 1..8).
- SCAN_DIV, 100000, clock cycles per digit slot, gap included (must be >= 2).
- GAP_CYC, 1000, cycles at the start of each slot with all digits off (0 <= GAP_CYC < SCAN_DIV).
- HEX_EN, 1, 1 = decode nibbles A-F as letters; 0 = nibbles 10-15 blank their digit's segments.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  when high at a clk edge, capture value/dp_mask/blank_mask into shadow
- value  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (rightmost)
- dp_mask  in  NUM_DIGITS  1 = light decimal point of that digit
- blank_mask  in  NUM_DIGITS  1 = digit fully dark, dp included
- lz_en  in  1  leading-zero suppression enable (live input, not shadowed)
- dig  out  NUM_DIGITS  digit enables, active-low, at most one bit low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse when the scan wraps back to digit 0

Behaviour:
Reset (async, rst=1):
- dig = all 1s, seg = 8'hFF, frame_tick = 0.
- Shadow value/masks = 0, digit index = 0, slot counter = 0, state = GAP.

Slot counter and index:
- Slot counter counts 0..SCAN_DIV-1 every cycle.
- At terminal count: counter -> 0, index increments, NUM_DIGITS-1 wraps to 0.
- frame_tick is asserted in the same cycle the index register becomes 0 via wrap (never at reset).

State machine (2 states):
- GAP, while counter < GAP_CYC: dig = all 1s, seg = 8'hFF.
- ON, while counter >= GAP_CYC: dig = ~(1 << index); seg = pattern.
- The pattern is computed from shadow and lz_en at the GAP->ON transition edge and held constant for the whole ON phase.
- GAP_CYC = 0: state is ON for the whole slot; the pattern is computed at the slot boundary.
- Outputs are registered. dig and seg change on the same clk edge, so there are no mixed-digit cycles.

Load:
- Shadow updates on the edge where load=1.
- A load during ON does not alter the displayed pattern until the next slot.
- load held high captures on every edge.

Decode (seg[6:0] when lit, seg[7]=1 before dp rule):
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
- HEX_EN=0: nibbles 10-15 give seg[6:0] = 7F.

Digit rules, in priority order:
1. blank_mask[i] = 1: seg = FF.
2. Leading-zero suppressed: seg[6:0] = 7F. Applies when lz_en=1, i > 0, and shadow nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
3. Otherwise: decoded pattern.

Decimal point:
- seg[7] = ~dp_mask[i] unless rule 1 applies.
- A leading-zero-suppressed digit still shows its dp.

Mid-operation reset:
- Reset mid-operation returns immediately to the reset values.
- After reset release, the first ON phase is digit 0, after GAP_CYC cycles.

Test Plan (bench params NUM_DIGITS=4, SCAN_DIV=8, GAP_CYC=2, HEX_EN=1):
1. Reset then load value=16'h1234, masks 0, lz_en=0:
   - Each slot shows 2 cycles dig=F, seg=FF, then 6 cycles ON.
   - Slot sequence: dig=E seg=99, dig=D seg=B0, dig=B seg=A4, dig=7 seg=F9.
   - frame_tick pulses once every 32 cycles.
2. value=16'h00A0, lz_en=1, dp_mask=4'b0100:
   - Digit 3 seg=FF; digit 2 seg=7F (suppressed, dp lit); digit 1 seg=88; digit 0 seg=C0.
   - With lz_en=0, digit 3 seg=C0 and digit 2 seg=40.
3. blank_mask=4'b0010 with dp_mask=4'b0010, value=16'h8888:
   - Digit 1 seg=FF.
   - Others seg=80.
4. Pulse load with a new value mid-ON of digit 1:
   - seg is unchanged for the rest of that ON phase.
   - The new value appears from digit 2's ON phase.
5. Assert rst mid-ON for one cycle, asynchronously:
   - dig=F and seg=FF within the same cycle.
   - Shadow reads 0 (digit 0 shows C0 after the gap); frame_tick is not pulsed at release.
6. Re-run with HEX_EN=0, GAP_CYC=0, value nibble 4'hF on digit 0:
   - seg=FF (no dp).
   - No all-off cycles between slots; dig is always one-hot-low.
